level_round_engine: RTL and testbench

Per-level gameplay engine answering the top-level game control unit's level handshake. While its `start` input is held high, it runs one guessing round: it captures a target key sequence, checks player key strobes against that sequence, and counts wrong guesses. It reports `level_done` and `guesses` back to the control unit. One instance is built per difficulty level; the control unit's level-start output drives `start`, and this block's `level_done` and `guesses` feed the control unit's level-done and guess-count inputs.

---
 rtl/level_round_engine.sv | 137 +++++++++++++
 tb/tb_level_round_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/level_round_engine.sv
// level_round_engine: one guessing round per level.
// While start is held high, the block loads a target key sequence, then checks
// the player's key strobes against it. It reports a win (level_done) or a
// lockout (locked) together with the wrong-guess count.
module level_round_engine #(
  parameter int unsigned SEQ_LEN    = 4,
  parameter int unsigned KEY_W      = 8,
  parameter int unsigned FAIL_LIMIT = 3
) (
  input  logic                       Clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [SEQ_LEN*KEY_W-1:0]   target,
  input  logic [KEY_W-1:0]           key_code,
  input  logic                       key_valid,
  output logic                       level_done,
  output logic [2:0]                 guesses,
  output logic [3:0]                 position,
  output logic                       hit,
  output logic                       miss,
  output logic                       locked
);

  localparam int unsigned POS_W   = 4;
  localparam int unsigned GUESS_W = 3;
  localparam int unsigned IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(SEQ_LEN - 1);
  localparam logic [GUESS_W-1:0] LOCK_CNT  = GUESS_W'(FAIL_LIMIT);
  localparam logic [GUESS_W-1:0] GUESS_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_DONE   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [SEQ_LEN-1:0][KEY_W-1:0]   tgt_q, tgt_d;
  logic [POS_W-1:0]                pos_q, pos_d;
  logic [GUESS_W-1:0]              guess_q, guess_d;
  logic                            hit_d, miss_d;
  logic [KEY_W-1:0]                cur_key;
  logic                            key_match;
  logic [GUESS_W-1:0]              guess_inc;

  // Stored element the player is expected to enter next.
  assign cur_key   = tgt_q[pos_q[IDX_W-1:0]];
  assign key_match = (key_code == cur_key);

  // Wrong-guess increment, saturating defensively at the counter maximum.
  assign guess_inc = (guess_q == GUESS_MAX) ? GUESS_MAX : guess_q + GUESS_W'(1);

  // Next-state and next-output decode; a low start always wins and clears the round.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pos_d   = pos_q;
    guess_d = guess_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;

    if (!start) begin
      state_d = S_IDLE;
      pos_d   = '0;
      guess_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          tgt_d   = target;
          pos_d   = '0;
          guess_d = '0;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          if (key_valid) begin
            if (key_match) begin
              hit_d = 1'b1;
              if (pos_q == LAST_POS) begin
                state_d = S_DONE;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              miss_d  = 1'b1;
              guess_d = guess_inc;
              if (guess_inc == LOCK_CNT) begin
                state_d = S_LOCKED;
              end
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_LOCKED: begin
          state_d = S_LOCKED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs; reset abandons the round at once.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      pos_q      <= '0;
      guess_q    <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      level_done <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      pos_q      <= pos_d;
      guess_q    <= guess_d;
      hit        <= hit_d;
      miss       <= miss_d;
      level_done <= (state_d == S_DONE);
      locked     <= (state_d == S_LOCKED);
    end
  end

  assign position = pos_q;
  assign guesses  = guess_q;

endmodule

// File: tb/tb_level_round_engine.sv
// Bench for level_round_engine: table of stimulus/expected records with a
// scoreboard queue, plus hand sequences around reset.
module tb_level_round_engine;

  localparam int unsigned SEQ_LEN    = 4;
  localparam int unsigned KEY_W      = 8;
  localparam int unsigned FAIL_LIMIT = 3;

  logic                      Clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      start = 1'b0;
  logic [SEQ_LEN*KEY_W-1:0]  target = '0;
  logic [KEY_W-1:0]          key_code = '0;
  logic                      key_valid = 1'b0;
  logic                      level_done;
  logic [2:0]                guesses;
  logic [3:0]                position;
  logic                      hit;
  logic                      miss;
  logic                      locked;

  level_round_engine #(
    .SEQ_LEN(SEQ_LEN), .KEY_W(KEY_W), .FAIL_LIMIT(FAIL_LIMIT)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .target(target),
    .key_code(key_code), .key_valid(key_valid), .level_done(level_done),
    .guesses(guesses), .position(position), .hit(hit), .miss(miss),
    .locked(locked)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ld;
    logic [2:0] g;
    logic [3:0] p;
    logic       h;
    logic       m;
    logic       l;
  } obs_t;

  typedef struct {
    logic                     st;
    logic                     kv;
    logic [KEY_W-1:0]         key;
    logic [SEQ_LEN*KEY_W-1:0] tgt;
    obs_t                     exp;
  } vec_t;

  // Element 0 sits in the low byte: sequence 1C,32,21,23 and AA,BB,CC,DD.
  localparam logic [31:0] T1 = {8'h23, 8'h21, 8'h32, 8'h1C};
  localparam logic [31:0] T2 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  vec_t vecs[$];
  obs_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic obs_t ob(input logic ld, input int g, input int p,
                              input logic h, input logic m, input logic l);
    obs_t o;
    o.ld = ld; o.g = 3'(g); o.p = 4'(p); o.h = h; o.m = m; o.l = l;
    return o;
  endfunction

  function automatic void add(input logic st, input logic kv, input logic [7:0] key,
                              input logic [31:0] tgt, input obs_t e);
    vec_t v;
    v.st = st; v.kv = kv; v.key = key; v.tgt = tgt; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t a;
    a = {level_done, guesses, position, hit, miss, locked};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got done=%0d g=%0d pos=%0d hit=%0d miss=%0d lock=%0d, want done=%0d g=%0d pos=%0d hit=%0d miss=%0d lock=%0d",
               name, a.ld, a.g, a.p, a.h, a.m, a.l, e.ld, e.g, e.p, e.h, e.m, e.l);
    end
  endtask

  // Drive one record away from the edge, queue its expectation, check after the edge.
  task automatic apply(input vec_t v, input int idx);
    obs_t e;
    @(negedge Clk);
    start     = v.st;
    key_valid = v.kv;
    key_code  = v.key;
    target    = v.tgt;
    sb.push_back(v.exp);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d", idx), e);
  endtask

  obs_t zero;

  initial begin
    zero = ob(0, 0, 0, 0, 0, 0);

    // Idle after reset release with start low.
    add(0, 0, 8'h00, T1, zero);
    // Clean win; the strobe during LOAD is ignored.
    add(1, 0, 8'h00, T1, zero);                 // LOAD
    add(1, 1, 8'h1C, T1, zero);                 // LOAD cycle strobe ignored -> PLAY
    add(1, 1, 8'h1C, T1, ob(0, 0, 1, 1, 0, 0));
    add(1, 1, 8'h32, T1, ob(0, 0, 2, 1, 0, 0));
    add(1, 1, 8'h21, T1, ob(0, 0, 3, 1, 0, 0));
    add(1, 1, 8'h23, T1, ob(1, 0, 3, 1, 0, 0)); // final key -> DONE
    add(1, 1, 8'h1C, T1, ob(1, 0, 3, 0, 0, 0)); // ignored in DONE
    add(1, 0, 8'h00, T1, ob(1, 0, 3, 0, 0, 0)); // pause cycle
    add(0, 0, 8'h00, T1, zero);                 // start falls
    // Lockout.
    add(1, 0, 8'h00, T1, zero);
    add(1, 0, 8'h00, T1, zero);
    add(1, 1, 8'h1C, T1, ob(0, 0, 1, 1, 0, 0));
    add(1, 1, 8'h55, T1, ob(0, 1, 1, 0, 1, 0));
    add(1, 1, 8'h55, T1, ob(0, 2, 1, 0, 1, 0));
    add(1, 1, 8'h55, T1, ob(0, 3, 1, 0, 1, 1));
    add(1, 1, 8'h32, T1, ob(0, 3, 1, 0, 0, 1)); // ignored in LOCKED
    add(0, 0, 8'h00, T1, zero);
    // Abort priority over a correct key.
    add(1, 0, 8'h00, T1, zero);
    add(1, 0, 8'h00, T1, zero);
    add(1, 1, 8'h1C, T1, ob(0, 0, 1, 1, 0, 0));
    add(1, 1, 8'h32, T1, ob(0, 0, 2, 1, 0, 0));
    add(0, 1, 8'h21, T1, zero);
    // Fresh round samples the new target.
    add(1, 0, 8'h00, T2, zero);
    add(1, 0, 8'h00, T2, zero);
    add(1, 1, 8'h1C, T2, ob(0, 1, 0, 0, 1, 0)); // old key now wrong
    add(1, 1, 8'hAA, T2, ob(0, 1, 1, 1, 0, 0));
    add(1, 1, 8'h00, T2, ob(0, 2, 1, 0, 1, 0));

    // Reset held with start high and strobes toggling.
    start  = 1'b1;
    target = T1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      key_valid = ~key_valid;
      key_code  = 8'h1C;
      @(posedge Clk);
      #1;
      check($sformatf("reset_hold%0d", i), zero);
    end
    @(negedge Clk);
    reset_n   = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset between edges while in PLAY with two misses.
    @(negedge Clk);
    key_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", zero);
    @(negedge Clk);
    reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("post_reset_load", zero);
    @(negedge Clk);
    key_valid = 1'b1;
    key_code  = 8'hAA;
    @(posedge Clk);
    #1;
    check("post_reset_load_ignore", zero);
    begin
      vec_t v;
      v.st = 1'b1; v.kv = 1'b1; v.key = 8'hAA; v.tgt = T2;
      v.exp = ob(0, 0, 1, 1, 0, 0);
      apply(v, 99);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
